// File: rtl/pulse_rate_meter.sv
// pulse_rate_meter: counts count_pulse events over fixed windows of
// WINDOW_CYCLES clocks and hands each window total off with valid/ready.
//
// Parameters:
//   WINDOW_CYCLES  window length in clk cycles (>= 2)
//   COUNT_WIDTH    width of the pulse accumulator and the result word
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   enable         measurement enable; low aborts the window and idles
//   count_pulse    event pulse from the upstream counter
//   out_ready      consumer accepts the result this cycle
//   clear_overrun  clears the sticky overrun flag
//   out_valid      result word valid
//   out_count      pulses counted in the last completed window
//   out_sat        accumulator saturated during that window
//   overrun        sticky: an unconsumed result was overwritten
//
// Optional build macro: PULSE_EDGE_DETECT_EN
//   Defined:   count_pulse is a level; only its rising edges are counted.
//   Undefined: every measuring cycle with count_pulse=1 is counted.

module pulse_rate_meter #(
    parameter int WINDOW_CYCLES = 16,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   count_pulse,
    input  logic                   out_ready,
    input  logic                   clear_overrun,
    output logic                   out_valid,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_sat,
    output logic                   overrun
);

    localparam int WIN_W =
        (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;

    localparam logic [WIN_W-1:0] WIN_LAST =
        WIN_W'(WINDOW_CYCLES - 1);

    localparam logic [COUNT_WIDTH-1:0] ACC_MAX = '1;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t                 state;
    logic [WIN_W-1:0]       win_cnt;
    logic [COUNT_WIDTH-1:0] acc;
    logic                   sat_flag;

    logic                   qual;
    logic [WIN_W-1:0]       win_base;
    logic [COUNT_WIDTH-1:0] acc_base;
    logic                   sat_base;
    logic [COUNT_WIDTH-1:0] acc_next;
    logic                   sat_next;
    logic                   last_cycle;
    logic                   load;
    logic                   xfer;
    logic                   ovr_set;

`ifdef PULSE_EDGE_DETECT_EN
    // Previous sample of the level; tracked in every state so that a
    // level already high on entry to MEASURE is not seen as an edge.
    logic pulse_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_prev <= 1'b0;
        end else begin
            pulse_prev <= count_pulse;
        end
    end

    assign qual = count_pulse & ~pulse_prev;
`else
    assign qual = count_pulse;
`endif

    // The cycle that leaves IDLE is already window cycle 0, so it is
    // evaluated from a clean window rather than from stored state.
    always_comb begin
        win_base = win_cnt;
        acc_base = acc;
        sat_base = sat_flag;
        if (state == IDLE) begin
            win_base = '0;
            acc_base = '0;
            sat_base = 1'b0;
        end
    end

    // Saturating accumulate: hold at the maximum and remember that a
    // pulse arrived with nowhere to go.
    always_comb begin
        acc_next = acc_base;
        sat_next = sat_base;
        if (qual) begin
            if (acc_base == ACC_MAX) begin
                sat_next = 1'b1;
            end else begin
                acc_next = acc_base + 1'b1;
            end
        end
    end

    assign last_cycle = (win_base == WIN_LAST);
    assign load       = enable & last_cycle;
    assign xfer       = out_valid & out_ready;
    assign ovr_set    = load & out_valid & ~out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            win_cnt   <= '0;
            acc       <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_sat   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (enable) begin
                state <= MEASURE;
                if (last_cycle) begin
                    win_cnt   <= '0;
                    acc       <= '0;
                    sat_flag  <= 1'b0;
                    out_count <= acc_next;
                    out_sat   <= sat_next;
                end else begin
                    win_cnt   <= win_base + 1'b1;
                    acc       <= acc_next;
                    sat_flag  <= sat_next;
                end
            end else begin
                // Abort: drop the partial window, keep the outputs.
                state    <= IDLE;
                win_cnt  <= '0;
                acc      <= '0;
                sat_flag <= 1'b0;
            end

            // A load during a transfer replaces the consumed word and
            // keeps valid high.
            if (load) begin
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end

            // A new overrun wins over a simultaneous clear.
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Randomized scoreboard bench for pulse_rate_meter: a window-level
// reference model queues expected results, a monitor checks transfers.

module tb_pulse_rate_meter;

    localparam int W   = 20;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    typedef struct {
        int cnt;
        bit sat;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          count_pulse;
    logic          out_ready;
    logic          clear_overrun;
    logic          out_valid;
    logic [CW-1:0] out_count;
    logic          out_sat;
    logic          overrun;

    int compared   = 0;
    int mismatched = 0;

    res_t q[$];
    int   pos      = 0;
    int   n        = 0;
    bit   mv       = 0;
    bit   m_ovr    = 0;
    bit   prev     = 0;
    bit   last_rst = 0;
    bit   running  = 0;

    pulse_rate_meter #(
        .WINDOW_CYCLES(W),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .count_pulse  (count_pulse),
        .out_ready    (out_ready),
        .clear_overrun(clear_overrun),
        .out_valid    (out_valid),
        .out_count    (out_count),
        .out_sat      (out_sat),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Window total from the number of qualifying pulses seen.
    function automatic res_t window_result(input int total);
        res_t r;
        r.cnt = (total > MAX) ? MAX : total;
        r.sat = (total > MAX);
        return r;
    endfunction

    // Advance the model over the clock edge that just passed, using the
    // inputs that were applied for that edge.
    task automatic model_step();
        bit   hit;
        bit   do_load;
        res_t r;
        last_rst = rst;
        if (rst) begin
            pos   = 0;
            n     = 0;
            mv    = 0;
            m_ovr = 0;
            prev  = 0;
            q.delete();
            return;
        end
`ifdef PULSE_EDGE_DETECT_EN
        hit = count_pulse && !prev;
`else
        hit = count_pulse;
`endif
        prev    = count_pulse;
        do_load = 0;
        if (enable) begin
            n += int'(hit);
            if (pos == W - 1) begin
                do_load = 1;
                r       = window_result(n);
                pos     = 0;
                n       = 0;
            end else begin
                pos++;
            end
        end else begin
            pos = 0;
            n   = 0;
        end
        if (do_load) begin
            if (mv && !out_ready) begin
                m_ovr = 1;
                if (q.size() > 0) void'(q.pop_back());
            end else if (clear_overrun) begin
                m_ovr = 0;
            end
            q.push_back(r);
            mv = 1;
        end else begin
            if (mv && out_ready) mv = 0;
            if (clear_overrun) m_ovr = 0;
        end
    endtask

    // Monitor: outputs are stable at the falling edge; a visible
    // valid&ready here is the transfer taken at the next rising edge.
    always @(negedge clk) begin
        if (running) begin
            compared++;
            if (out_valid !== (q.size() != 0)) begin
                mismatched++;
                $display("FAIL out_valid: got %b expected %b",
                         out_valid, (q.size() != 0));
            end
            compared++;
            if (overrun !== m_ovr) begin
                mismatched++;
                $display("FAIL overrun: got %b expected %b",
                         overrun, m_ovr);
            end
            if (last_rst) begin
                compared++;
                if (out_count !== '0 || out_sat !== 1'b0) begin
                    mismatched++;
                    $display("FAIL reset outputs: got %0d/%b expected 0/0",
                             out_count, out_sat);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1
                && q.size() != 0) begin
                res_t r;
                r = q.pop_front();
                compared++;
                if (out_count !== CW'(r.cnt) || out_sat !== r.sat) begin
                    mismatched++;
                    $display("FAIL result: got %0d/%b expected %0d/%b",
                             out_count, out_sat, r.cnt, r.sat);
                end
            end
        end
    end

    initial begin
        int unsigned pd;
        int unsigned pr;
        int unsigned ed;
        int unsigned len;
        rst           = 1'b1;
        enable        = 1'b0;
        count_pulse   = 1'b0;
        out_ready     = 1'b0;
        clear_overrun = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            model_step();
        end
        running = 1;
        rst     = 1'b0;
        for (int seg = 0; seg < 80; seg++) begin
            case (seg % 5)
                0: pd = 100;
                1: pd = 0;
                default: pd = $urandom_range(5, 95);
            endcase
            pr  = (seg % 3 == 0) ? 0 : $urandom_range(10, 100);
            ed  = (seg % 4 == 3) ? 8 : ((seg % 7 == 0) ? 1 : 0);
            len = $urandom_range(W, 6 * W);
            for (int c = 0; c < int'(len); c++) begin
                rst           = ($urandom_range(0, 999) < 3);
                enable        = ($urandom_range(0, 99) >= ed);
                count_pulse   = ($urandom_range(0, 99) < pd);
                out_ready     = ($urandom_range(0, 99) < pr);
                clear_overrun = ($urandom_range(0, 99) < 4);
                @(posedge clk);
                #1;
                model_step();
            end
        end
        rst           = 1'b0;
        enable        = 1'b0;
        out_ready     = 1'b1;
        clear_overrun = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            model_step();
        end
        @(negedge clk);
        #1;
        running = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pulse_rate_meter.md
Name: pulse_rate_meter

Overview:
- Downstream consumer of the event counter's single-cycle `count_pulse` output.
- Counts pulses over a fixed window of WINDOW_CYCLES clocks, then presents each window's total as a result word.
- Results are handed off with a valid/ready handshake to a register/report stage.
- Flags windows whose count saturated, and results overwritten before they were consumed.

Parameters:
- WINDOW_CYCLES, 16, window length in clk cycles (>=2).
- COUNT_WIDTH, 8, width of pulse accumulator and result.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- enable  input  1  measurement enable; low aborts and idles.
- count_pulse  input  1  event pulse from upstream counter.
- out_ready  input  1  consumer accepts result this cycle.
- clear_overrun  input  1  clears sticky overrun flag.
- out_valid  output  1  result word valid.
- out_count  output  COUNT_WIDTH  pulses counted in last completed window.
- out_sat  output  1  accumulator saturated during that window.
- overrun  output  1  sticky: unconsumed result was overwritten.

Behaviour:
- Reset and synchronicity:
  - One clock, clk. Reset rst is synchronous, active-high.
  - On rst=1 at a clk edge: state=IDLE, window counter=0, accumulator=0, sat flag=0, out_valid=0, out_count=0, out_sat=0, overrun=0.
  - rst overrides every other input.
- State machine, IDLE / MEASURE:
  - IDLE -> MEASURE when enable=1. That same cycle is window cycle 0; its pulse is counted.
  - MEASURE -> IDLE when enable=0. The partial window is discarded: accumulator, window counter and sat flag are zeroed. Output registers and overrun are untouched.
  - In IDLE, nothing is counted.
- Window timing:
  - Window counter width = clog2(WINDOW_CYCLES). It increments each MEASURE cycle.
  - At count WINDOW_CYCLES-1 (last window cycle), that cycle's pulse is included.
  - The total is loaded into out_count/out_sat at the edge ending that cycle, and out_valid=1 from the next cycle.
  - Accumulator, window counter and sat flag restart at 0 with no gap. The next window starts the following cycle.
  - Latency: result visible exactly 1 cycle after the last window cycle.
- Accumulation:
  - +1 per qualifying pulse.
  - Saturates at 2^COUNT_WIDTH-1 and never wraps. A further pulse at saturation sets the sat flag.
- Handshake:
  - Transfer occurs when out_valid=1 and out_ready=1 at a clk edge; out_valid then clears.
  - out_count/out_sat are held stable while out_valid=1 and out_ready=0, except on overrun.
  - out_ready is ignored when out_valid=0.
- Simultaneous load and transfer:
  - Old result consumed, new result loaded, out_valid stays 1, no overrun.
- Overrun:
  - Condition: a new result loads while out_valid=1 and out_ready=0.
  - New result overwrites old, and overrun=1.
  - overrun is sticky until clear_overrun=1 or rst.
  - If clear_overrun and a new overrun occur in the same cycle, set wins (overrun=1).
- Enable dropping on the last window cycle: no result is produced, and the window is discarded.

Optional Feature:
- Macro: PULSE_EDGE_DETECT_EN.
- Defined:
  - count_pulse is treated as a level.
  - A qualifying pulse is count_pulse=1 with previous-cycle sample=0.
  - The previous-sample register updates every cycle in all states, and resets to 0.
  - A level already high when entering MEASURE is not counted.
- Undefined: every MEASURE cycle with count_pulse=1 counts.

Test Plan:
- Single pulses: rst, then enable=1, out_ready=1, one count_pulse at cycles 3, 7, 11 of a 16-cycle window -> out_valid=1 for one cycle, 1 cycle after window cycle 15, with out_count=3, out_sat=0.
- Continuous level: count_pulse held 1 for a whole window -> out_count=16 without macro; out_count=1 with PULSE_EDGE_DETECT_EN (level rose before enable -> 0).
- Saturation: COUNT_WIDTH=3, count_pulse held 1 for 16 cycles (no macro) -> out_count=7, out_sat=1.
- Overrun: out_ready=0 across two window completions, pulses 2 then 5 -> after the second load out_count=5, overrun=1 stays set; clear_overrun=1 for 1 cycle -> overrun=0.
- Abort: enable dropped at window cycle 9 after 4 pulses, re-raised later with 1 pulse in a full window -> only out_count=1 produced, no stale partial.
- Reset mid-window: rst=1 at window cycle 5 with out_valid=1 -> next cycle all outputs 0, state IDLE; counting restarts at window cycle 0 once enable=1 with rst=0.
